timer_irq_peripheral: RTL

- Memory-mapped timer peripheral that generates the IRQ input consumed by the single-cycle CPU's Control unit.
- Sits on the data-memory bus next to data RAM and is selected by address.
- Counts up to overflow, reloads from a programmable value, and raises a level IRQ that stays high until software clears it.
- Also provides a free-running read-only cycle counter (systick).

---
 rtl/timer_irq_peripheral.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/timer_irq_peripheral.sv
// ---------------------------------------------------------------------------
// timer_irq_peripheral
//
// Memory-mapped timer that sits on the data-memory bus beside data RAM and
// drives the IRQ input of the CPU Control unit. It also provides a
// free-running cycle counter (SYSTICK).
//
// Register map (byte offsets from BASE_ADDR, Address[1:0] ignored):
//   0x00 TH      reload value                     read/write
//   0x04 TL      up-counter                       read/write
//   0x08 TCON    [0] run, [1] irq enable,
//                [2] irq status, [31:3] read 0     read/write
//   0x0C SYSTICK free-running cycle count          read-only
//
// Ports:
//   clk       system clock, every state update happens on its rising edge
//   reset     asynchronous active-high reset, clears all state at once
//   MemRd     bus read strobe
//   MemWr     bus write strobe, the write commits on the rising clk edge
//   Address   32-bit byte address
//   WriteData 32-bit bus write data
//   ReadData  32-bit combinational read data (0 on miss or when MemRd=0)
//   IRQ       level interrupt request, a copy of TCON[2]
//
// Bus handshake: there is no valid/ready pair. The peripheral never stalls,
// so a strobe (MemRd or MemWr) together with a hitting Address is always
// accepted: reads are answered in the same cycle, writes on the next edge.
// ---------------------------------------------------------------------------
module timer_irq_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    localparam logic [1:0] SEL_TH      = 2'd0;
    localparam logic [1:0] SEL_TL      = 2'd1;
    localparam logic [1:0] SEL_TCON    = 2'd2;
    localparam logic [1:0] SEL_SYSTICK = 2'd3;

    logic [31:0] th_q,      th_d;
    logic [31:0] tl_q,      tl_d;
    logic [2:0]  tcon_q,    tcon_d;
    logic [31:0] systick_q, systick_d;
    logic [15:0] ps_q,      ps_d;

    // Decode by subtracting the base so an address below BASE_ADDR wraps to
    // a huge offset and misses, and the base need not be 16-byte aligned.
    logic [31:0] addr_off;
    logic        addr_hit;
    logic [1:0]  addr_sel;
    logic        unused_addr_bits;

    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        tick;
    logic        overflow;

    always_comb begin
        addr_off         = Address - BASE_ADDR;
        addr_hit         = (addr_off[31:4] == 28'd0);
        addr_sel         = addr_off[3:2];
        unused_addr_bits = ^addr_off[1:0];
    end

    always_comb begin
        wr_th    = MemWr && addr_hit && (addr_sel == SEL_TH);
        wr_tl    = MemWr && addr_hit && (addr_sel == SEL_TL);
        wr_tcon  = MemWr && addr_hit && (addr_sel == SEL_TCON);
        tick     = tcon_q[0] && (ps_q == PS_LAST);
        overflow = tick && (tl_q == 32'hFFFF_FFFF);
    end

    // Next-state logic. CPU writes take priority over hardware updates of the
    // same register; a TH write on an overflow edge still reloads the old TH
    // because the reload reads th_q.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        systick_d = systick_q + 32'd1;
        ps_d      = ps_q;

        if (wr_th) begin
            th_d = WriteData;
        end

        if (wr_tl) begin
            tl_d = WriteData;
        end else if (overflow) begin
            tl_d = th_q;
        end else if (tick) begin
            tl_d = tl_q + 32'd1;
        end

        // Overflow only ever sets the status bit; a TCON write on the same
        // edge wins, so writing bit2=0 then drops that overflow.
        if (wr_tcon) begin
            tcon_d = WriteData[2:0];
        end else if (overflow && tcon_q[1]) begin
            tcon_d[2] = 1'b1;
        end

        // The prescaler restarts from 0 whenever the timer is (or is about
        // to be) stopped, so a restart always gets a full PRESCALE period.
        if (!tcon_d[0]) begin
            ps_d = 16'd0;
        end else if (tick) begin
            ps_d = 16'd0;
        end else if (tcon_q[0]) begin
            ps_d = ps_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= 32'd0;
            tl_q      <= 32'd0;
            tcon_q    <= 3'd0;
            systick_q <= 32'd0;
            ps_q      <= 16'd0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
            ps_q      <= ps_d;
        end
    end

    always_comb begin
        ReadData = 32'd0;
        if (MemRd && addr_hit) begin
            case (addr_sel)
                SEL_TH:      ReadData = th_q;
                SEL_TL:      ReadData = tl_q;
                SEL_TCON:    ReadData = {29'd0, tcon_q};
                SEL_SYSTICK: ReadData = systick_q;
                default:     ReadData = 32'd0;
            endcase
        end
    end

    assign IRQ = tcon_q[2];

endmodule
